xyolo_write_ctrl: RTL and testbench
===================================

// Module: xyolo_write_ctrl
// PURPOSE
//  Sequencer for the xyolo write stage. Drives the internal (port B) side of
//  the vread pixel memory and the vwrite result memories, and issues the
//  ld_acc/ld_res/ld_mp pulses that make the xyolo array accumulate, emit and
//  pool results. It runs on the same global_run as the external address
//  generators, and raises done when the last result has been written.
// PARAMETERS
//  RD_ADDR_W  10  vread internal read address width (PIXEL_INT_ADDR_W)
//  WR_ADDR_W  10  vwrite internal write address width (VWRITE_ADDR_W)
//  CNT_W      16  kernel-length and output-count width
//  N_VECT     16  number of xyolo/vwrite lanes (nYOLOvect)
//  N_MACS_W   1   ld_nmac width
//  RD_LAT     2   cycles from vread_enB to the pixel at xyolo (mem + out reg)
//  RES_LAT    2   cycles from ld_res to valid data at the vwrite_mem input
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset
//  run          in   1          start pulse; configuration sampled on this cycle
//  done         out  1          idle/complete flag
//  cfg_klen     in   CNT_W      pixel reads per output (kernel length)
//  cfg_nout     in   CNT_W      outputs to produce
//  cfg_rd_start in   RD_ADDR_W  first read address
//  cfg_rd_gap   in   RD_ADDR_W  added to the read base between outputs
//  cfg_wr_start in   WR_ADDR_W  first write address
//  cfg_wr_mask  in   N_VECT     lanes enabled for writing
//  cfg_nmac     in   N_MACS_W   MAC select, held on ld_nmac during the run
//  cfg_maxpool  in   1          2x2 pooling mode (only with the macro)
//  vread_enB    out  1          vread read enable
//  vread_addrB  out  RD_ADDR_W  vread read address
//  ld_acc       out  1          xyolo: (re)start accumulation with this pixel
//  ld_res       out  1          xyolo: latch accumulated result
//  ld_mp        out  1          xyolo: max-combine with the held result
//  ld_nmac      out  N_MACS_W   xyolo MAC select
//  vwrite_enB   out  N_VECT     per-lane vwrite write enable
//  vwrite_addrB out  WR_ADDR_W  vwrite write address
// BEHAVIOUR
//  - rst is asynchronous and active-high; the clock is clk. Reset values:
//    done=1, ld_nmac=0, and every other output 0. The state goes to IDLE,
//    all counters and delay lines clear, and any pending writes are dropped.
//  - States:
//    IDLE -> ISSUE on run. If cfg_klen==0 or cfg_nout==0, the run goes
//      instead to FIN for one cycle with no enables.
//    ISSUE: every cycle, vread_enB=1 and addr=base+k. When
//      k==cfg_klen-1: k=0, base+=cfg_klen+cfg_rd_gap, o++. When
//      o==cfg_nout-1 also holds, go to DRAIN.
//    DRAIN: wait until the delay lines are empty, then go to IDLE.
//  - done falls the cycle after run. It rises the cycle after the last
//    vwrite_enB pulse. A run seen outside IDLE is ignored.
//  - Issue-stage tags (first=k==0, last=k==klen-1) travel in a RD_LAT delay
//    line. ld_acc is first delayed by RD_LAT, so it aligns with pixel k=0.
//  - ld_res pulses the cycle after the pixel tagged last reaches xyolo
//    (issue+RD_LAT+1). Between outputs this is the same cycle as the next
//    ld_acc, so outputs run back-to-back with no bubble.
//  - A write fires RES_LAT cycles after each ld_res that produces a result:
//    vwrite_enB=cfg_wr_mask and vwrite_addrB=wr_ptr, then wr_ptr++ (wraps
//    modulo 2^WR_ADDR_W). Outside write cycles, vwrite_enB=0.
//  - Read address wraps modulo 2^RD_ADDR_W. There is no overflow flag.
//  - Latency, non-pooled: the first write is at run+1+(klen-1)+RD_LAT+1+RES_LAT.
//    Total run length is cfg_nout*cfg_klen cycles of issue plus drain.
// CONFIGURATION
//  - XYOLO_WRITE_CTRL_MAXPOOL_EN defined: when cfg_maxpool=1, outputs are
//    grouped in fours. ld_mp pulses with ld_res for outputs 2..4 of each
//    group. A write fires only after the 4th, so cfg_nout/4 writes occur;
//    a partial tail group is still written after its last output.
//  - Macro undefined: cfg_maxpool is ignored, ld_mp is tied to 0, and
//    every output is written.
// TESTING
//  1. klen=3, nout=2, rd_start=8, gap=1, wr_start=5, mask=all ones
//     -> reads 8,9,10,12,13,14. ld_acc at cycles 3,6; ld_res at 6,9;
//     vwrite_enB at 8(addr5), 11(addr6); done rises at 12.
//  2. klen=1, nout=4 -> ld_acc and ld_res high on consecutive cycles;
//     4 writes back-to-back at addr 0..3.
//  3. klen=0 or nout=0 -> no vread_enB or vwrite_enB pulses; done low
//     for 2 cycles, then high.
//  4. run repeated in ISSUE, and rst asserted mid-ISSUE -> the repeated run
//     is ignored; after rst all outputs are 0, done=1, and no late writes.
//  5. MAXPOOL_EN: klen=2, nout=8, maxpool=1 -> ld_mp on outputs 2-4 and
//     6-8; exactly 2 writes at addr 0,1.
//  6. wr_start=2^WR_ADDR_W-1, nout=2 -> writes land at max, then 0.

Source files
------------

// File: rtl/xyolo_write_ctrl.sv
// rtl/xyolo_write_ctrl.sv - xyolo write-stage sequencer (vread port B reads, ld_* pulses, vwrite port B writes)
// Optional 2x2 pooling: define XYOLO_WRITE_CTRL_MAXPOOL_EN.
module xyolo_write_ctrl #(
  parameter int RD_ADDR_W = 10,
  parameter int WR_ADDR_W = 10,
  parameter int CNT_W     = 16,
  parameter int N_VECT    = 16,
  parameter int N_MACS_W  = 1,
  parameter int RD_LAT    = 2,
  parameter int RES_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 done,
  input  logic [CNT_W-1:0]     cfg_klen,
  input  logic [CNT_W-1:0]     cfg_nout,
  input  logic [RD_ADDR_W-1:0] cfg_rd_start,
  input  logic [RD_ADDR_W-1:0] cfg_rd_gap,
  input  logic [WR_ADDR_W-1:0] cfg_wr_start,
  input  logic [N_VECT-1:0]    cfg_wr_mask,
  input  logic [N_MACS_W-1:0]  cfg_nmac,
  input  logic                 cfg_maxpool,
  output logic                 vread_enB,
  output logic [RD_ADDR_W-1:0] vread_addrB,
  output logic                 ld_acc,
  output logic                 ld_res,
  output logic                 ld_mp,
  output logic [N_MACS_W-1:0]  ld_nmac,
  output logic [N_VECT-1:0]    vwrite_enB,
  output logic [WR_ADDR_W-1:0] vwrite_addrB
);

  typedef enum logic [1:0] {IDLE, ISSUE, FIN, DRAIN} state_t;
  state_t state;

  logic [CNT_W-1:0]     klen_r, nout_r, k_r, o_r;
  logic [RD_ADDR_W-1:0] base_r, gap_r;
  logic [N_VECT-1:0]    mask_r;
  logic [WR_ADDR_W-1:0] wr_ptr;
  logic [RD_LAT-1:0]    first_sr, last_sr;
  logic                 last_at;
  logic [RES_LAT-1:0]   wr_sr;
  logic                 start, cfg_ok, produce, pool_pending, pending;

  // Values of the read issued at this edge; the first read comes straight from cfg.
  logic                 iss_v, iss_first, iss_last, iss_fin;
  logic [CNT_W-1:0]     iss_k, iss_o, iss_klen, iss_nout;
  logic [RD_ADDR_W-1:0] iss_base, iss_gap;

  assign start  = (state == IDLE) && run;
  assign cfg_ok = (cfg_klen != '0) && (cfg_nout != '0);

  always_comb begin
    iss_v    = 1'b0;
    iss_k    = k_r;
    iss_o    = o_r;
    iss_base = base_r;
    iss_gap  = gap_r;
    iss_klen = klen_r;
    iss_nout = nout_r;
    if (start && cfg_ok) begin
      iss_v    = 1'b1;
      iss_k    = '0;
      iss_o    = '0;
      iss_base = cfg_rd_start;
      iss_gap  = cfg_rd_gap;
      iss_klen = cfg_klen;
      iss_nout = cfg_nout;
    end else if (state == ISSUE) begin
      iss_v = 1'b1;
    end
    iss_first = iss_v && (iss_k == '0);
    iss_last  = iss_v && (iss_k == iss_klen - CNT_W'(1));
    iss_fin   = iss_last && (iss_o == iss_nout - CNT_W'(1));
  end

  assign pending = (|first_sr) || (|last_sr) || last_at || (|wr_sr) || pool_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      done         <= 1'b1;
      klen_r       <= '0;
      nout_r       <= '0;
      k_r          <= '0;
      o_r          <= '0;
      base_r       <= '0;
      gap_r        <= '0;
      mask_r       <= '0;
      wr_ptr       <= '0;
      first_sr     <= '0;
      last_sr      <= '0;
      last_at      <= 1'b0;
      wr_sr        <= '0;
      vread_enB    <= 1'b0;
      vread_addrB  <= '0;
      ld_acc       <= 1'b0;
      ld_res       <= 1'b0;
      ld_nmac      <= '0;
      vwrite_enB   <= '0;
      vwrite_addrB <= '0;
    end else begin
      vread_enB <= iss_v;
      if (iss_v) begin
        vread_addrB <= iss_base + RD_ADDR_W'(iss_k);
        if (iss_last) begin
          k_r    <= '0;
          base_r <= iss_base + RD_ADDR_W'(iss_klen) + iss_gap;
          o_r    <= iss_o + CNT_W'(1);
        end else begin
          k_r    <= iss_k + CNT_W'(1);
          base_r <= iss_base;
          o_r    <= iss_o;
        end
      end

      for (int i = RD_LAT - 1; i > 0; i--) begin
        first_sr[i] <= first_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
      first_sr[0] <= iss_first;
      last_sr[0]  <= iss_last;
      ld_acc      <= first_sr[RD_LAT-1];
      last_at     <= last_sr[RD_LAT-1];
      ld_res      <= last_at;

      for (int i = RES_LAT - 1; i > 0; i--) wr_sr[i] <= wr_sr[i-1];
      wr_sr[0] <= last_at && produce;
      if (wr_sr[RES_LAT-1]) begin
        vwrite_enB   <= mask_r;
        vwrite_addrB <= wr_ptr;
        wr_ptr       <= wr_ptr + WR_ADDR_W'(1);
      end else begin
        vwrite_enB <= '0;
      end

      case (state)
        IDLE: if (run) begin
          done    <= 1'b0;
          klen_r  <= cfg_klen;
          nout_r  <= cfg_nout;
          gap_r   <= cfg_rd_gap;
          mask_r  <= cfg_wr_mask;
          wr_ptr  <= cfg_wr_start;
          ld_nmac <= cfg_nmac;
          state   <= !cfg_ok ? FIN : (iss_fin ? DRAIN : ISSUE);
        end
        ISSUE: if (iss_fin) state <= DRAIN;
        FIN:   state <= DRAIN;
        DRAIN: if (!pending) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
  logic              pool_r, fin_at;
  logic [1:0]        pos_r;
  logic [RD_LAT-1:0] fin_sr;

  // Only the 4th output of a group, or the final output of the run, is written.
  assign produce      = !pool_r || (pos_r == 2'd3) || fin_at;
  assign pool_pending = (|fin_sr) || fin_at;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_r <= 1'b0;
      pos_r  <= '0;
      fin_sr <= '0;
      fin_at <= 1'b0;
      ld_mp  <= 1'b0;
    end else begin
      if (start) pool_r <= cfg_maxpool;
      for (int i = RD_LAT - 1; i > 0; i--) fin_sr[i] <= fin_sr[i-1];
      fin_sr[0] <= iss_fin;
      fin_at    <= fin_sr[RD_LAT-1];
      if (last_at) begin
        ld_mp <= pool_r && (pos_r != 2'd0);
        pos_r <= (!pool_r || fin_at || pos_r == 2'd3) ? 2'd0 : pos_r + 2'd1;
      end else begin
        ld_mp <= 1'b0;
      end
    end
  end
`else
  logic unused_maxpool;
  assign unused_maxpool = cfg_maxpool;
  assign produce        = 1'b1;
  assign pool_pending   = 1'b0;
  assign ld_mp          = 1'b0;
`endif

endmodule

// File: tb/tb_xyolo_write_ctrl.sv
// tb/tb_xyolo_write_ctrl.sv - scoreboard bench for xyolo_write_ctrl
module tb_xyolo_write_ctrl;

`ifdef XYOLO_WRITE_CTRL_MAXPOOL_EN
  localparam bit POOL_BUILD = 1'b1;
`else
  localparam bit POOL_BUILD = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] mask;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        done;
  logic [15:0] cfg_klen = '0, cfg_nout = '0;
  logic [9:0]  cfg_rd_start = '0, cfg_rd_gap = '0, cfg_wr_start = '0;
  logic [15:0] cfg_wr_mask = '0;
  logic [0:0]  cfg_nmac = '0;
  logic        cfg_maxpool = 1'b0;
  logic        vread_enB, ld_acc, ld_res, ld_mp;
  logic [9:0]  vread_addrB, vwrite_addrB;
  logic [0:0]  ld_nmac;
  logic [15:0] vwrite_enB;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  rd_q[$], wr_q[$];
  int   acc_q[$], res_q[$], mp_q[$];
  ev_t  mon_ev;
  int   mon_c;

  xyolo_write_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .cfg_klen(cfg_klen), .cfg_nout(cfg_nout), .cfg_rd_start(cfg_rd_start),
    .cfg_rd_gap(cfg_rd_gap), .cfg_wr_start(cfg_wr_start), .cfg_wr_mask(cfg_wr_mask),
    .cfg_nmac(cfg_nmac), .cfg_maxpool(cfg_maxpool),
    .vread_enB(vread_enB), .vread_addrB(vread_addrB),
    .ld_acc(ld_acc), .ld_res(ld_res), .ld_mp(ld_mp), .ld_nmac(ld_nmac),
    .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every DUT pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (vread_enB) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++; $display("FAIL rd_extra: cyc %0d addr %0d, required no read", cyc, vread_addrB);
        end else begin
          mon_ev = rd_q.pop_front();
          if (int'(vread_addrB) !== mon_ev.addr || cyc !== mon_ev.cyc) begin
            errors++; $display("FAIL rd: got cyc %0d addr %0d, required cyc %0d addr %0d", cyc, vread_addrB, mon_ev.cyc, mon_ev.addr);
          end
        end
      end
      if (vwrite_enB !== 16'h0) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++; $display("FAIL wr_extra: cyc %0d addr %0d, required no write", cyc, vwrite_addrB);
        end else begin
          mon_ev = wr_q.pop_front();
          if (int'(vwrite_addrB) !== mon_ev.addr || cyc !== mon_ev.cyc || vwrite_enB !== mon_ev.mask) begin
            errors++; $display("FAIL wr: got cyc %0d addr %0d en %h, required cyc %0d addr %0d en %h", cyc, vwrite_addrB, vwrite_enB, mon_ev.cyc, mon_ev.addr, mon_ev.mask);
          end
        end
      end
      if (ld_acc) begin
        checks++;
        mon_c = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
        if (cyc !== mon_c) begin errors++; $display("FAIL ld_acc: got cyc %0d, required %0d", cyc, mon_c); end
      end
      if (ld_res) begin
        checks++;
        mon_c = (res_q.size() != 0) ? res_q.pop_front() : -1;
        if (cyc !== mon_c) begin errors++; $display("FAIL ld_res: got cyc %0d, required %0d", cyc, mon_c); end
      end
      if (ld_mp) begin
        checks++;
        mon_c = (mp_q.size() != 0) ? mp_q.pop_front() : -1;
        if (cyc !== mon_c) begin errors++; $display("FAIL ld_mp: got cyc %0d, required %0d", cyc, mon_c); end
      end
    end
  end

  task automatic start_run(input int klen, input int nout, input int rs, input int gap, input int ws,
                           input logic [15:0] mask, input logic mp, input logic nm, output int exp_done);
    int  t0, widx, rc;
    ev_t e;
    @(negedge clk);
    t0 = cyc;
    cfg_klen = 16'(klen); cfg_nout = 16'(nout); cfg_rd_start = 10'(rs); cfg_rd_gap = 10'(gap);
    cfg_wr_start = 10'(ws); cfg_wr_mask = mask; cfg_maxpool = mp; cfg_nmac = nm;
    run = 1'b1;
    exp_done = t0 + 3;
    widx = 0;
    if (klen != 0 && nout != 0) begin
      for (int o = 0; o < nout; o++) begin
        for (int k = 0; k < klen; k++) begin
          e.cyc = t0 + 1 + o * klen + k; e.addr = (rs + o * (klen + gap) + k) % 1024; e.mask = '0;
          rd_q.push_back(e);
        end
        acc_q.push_back(t0 + 3 + o * klen);
        rc = t0 + (o + 1) * klen + 3;
        res_q.push_back(rc);
        if (POOL_BUILD && mp && (o % 4 != 0)) mp_q.push_back(rc);
        if (!(POOL_BUILD && mp) || (o % 4 == 3) || (o == nout - 1)) begin
          e.cyc = rc + 2; e.addr = (ws + widx) % 1024; e.mask = mask;
          wr_q.push_back(e);
          widx++;
          exp_done = rc + 3;
        end
      end
    end
  endtask

  task automatic finish_run(input int exp_done, input int rerun, input logic nm, input string name);
    int got;
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_fall: got %b, required 0", name, done); end
    got = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      run = (rerun != 0 && i == rerun);
      if (done === 1'b1) begin got = cyc; break; end
    end
    run = 1'b0;
    checks++;
    if (got !== exp_done) begin errors++; $display("FAIL %s done_rise: got cyc %0d, required %0d", name, got, exp_done); end
    checks++;
    if (ld_nmac !== nm) begin errors++; $display("FAIL %s ld_nmac: got %b, required %b", name, ld_nmac, nm); end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() + wr_q.size() + acc_q.size() + res_q.size() + mp_q.size() != 0) begin
      errors++; $display("FAIL %s missing: got %0d events still pending, required 0", name,
                         rd_q.size() + wr_q.size() + acc_q.size() + res_q.size() + mp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({vread_enB, ld_acc, ld_res, ld_mp, vwrite_enB, vread_addrB, vwrite_addrB, ld_nmac} !== '0 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s outputs: got done %b rd %b/%0d acc %b res %b mp %b wr %h/%0d nmac %b, required done 1 and all 0",
               name, done, vread_enB, vread_addrB, ld_acc, ld_res, ld_mp, vwrite_enB, vwrite_addrB, ld_nmac);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_basic();
    int ed;
    start_run(3, 2, 8, 1, 5, 16'hFFFF, 1'b0, 1'b1, ed);
    finish_run(ed, 0, 1'b1, "basic");
  endtask

  task automatic test_back_to_back();
    int ed;
    start_run(1, 4, 20, 0, 0, 16'h00F0, 1'b0, 1'b0, ed);
    finish_run(ed, 0, 1'b0, "klen1");
  endtask

  task automatic test_zero();
    int ed;
    start_run(0, 3, 4, 0, 7, 16'hFFFF, 1'b0, 1'b1, ed);
    finish_run(ed, 0, 1'b1, "klen0");
    start_run(2, 0, 4, 0, 7, 16'hFFFF, 1'b0, 1'b0, ed);
    finish_run(ed, 0, 1'b0, "nout0");
  endtask

  task automatic test_run_ignored();
    int ed;
    start_run(4, 4, 100, 2, 30, 16'h1234, 1'b0, 1'b1, ed);
    finish_run(ed, 3, 1'b1, "rerun");
  endtask

  task automatic test_reset_mid();
    int ed;
    start_run(4, 4, 0, 0, 0, 16'hFFFF, 1'b0, 1'b1, ed);
    @(negedge clk);
    run = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b1;
    rd_q.delete(); wr_q.delete(); acc_q.delete(); res_q.delete(); mp_q.delete();
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_idle_outputs("rst_mid_after");
  endtask

  task automatic test_maxpool();
    int ed;
    start_run(2, 8, 0, 0, 0, 16'hFFFF, 1'b1, 1'b0, ed);
    finish_run(ed, 0, 1'b0, "maxpool");
    start_run(1, 6, 0, 0, 9, 16'h0F0F, 1'b1, 1'b0, ed);
    finish_run(ed, 0, 1'b0, "maxpool_tail");
  endtask

  task automatic test_wrap();
    int ed;
    start_run(2, 2, 1022, 0, 1023, 16'hFFFF, 1'b0, 1'b1, ed);
    finish_run(ed, 0, 1'b1, "wrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_run_ignored();
    test_reset_mid();
    test_maxpool();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
